// File: rtl/alu_test_sequencer_if.sv
// ALU operand/start/done bundle between the test sequencer and the ALU.
// master drives A/B/op/alu_start; slave returns alu_done/alu_result.
interface alu_test_sequencer_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  op;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;

  modport master (
    output A,
    output B,
    output op,
    output alu_start,
    input  alu_done,
    input  alu_result
  );

  modport slave (
    input  A,
    input  B,
    input  op,
    input  alu_start,
    output alu_done,
    output alu_result
  );
endinterface

// File: rtl/alu_test_sequencer.sv
// Steps an 8-entry operand/opcode table into a multicycle ALU on a button
// press or auto-tick; ports: clk, rst, forward, auto_mode, alu bundle,
// result, result_valid, vec_index, busy, timeout_err.
module alu_test_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int AUTO_DELAY     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 forward,
  input  logic                 auto_mode,
  alu_test_sequencer_if.master alu,
  output logic [31:0]          result,
  output logic                 result_valid,
  output logic [2:0]           vec_index,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(AUTO_DELAY + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] ALAST = AW'(AUTO_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t state;
  state_t state_nx;

  logic          s1;
  logic          s2;
  logic          s3;
  logic          fwd_pulse;
  logic [AW-1:0] acnt;
  logic [TW-1:0] tcnt;
  logic          trig;
  logic          tmo;

  function automatic logic [68:0] tbl(input logic [2:0] i);
    logic [68:0] v;
    unique case (i)
      3'd0: v = {32'd5,  32'd20, 5'd1};
      3'd1: v = {32'd10, 32'd2,  5'd2};
      3'd2: v = {32'd15, 32'd11, 5'd3};
      3'd3: v = {32'd55, 32'd20, 5'd4};
      3'd4: v = {32'd6,  32'd22, 5'd5};
      3'd5: v = {32'd8,  32'd1,  5'd6};
      3'd6: v = {32'd0,  32'd12, 5'd7};
      3'd7: v = {32'd14, 32'd98, 5'd8};
      default: v = '0;
    endcase
    return v;
  endfunction

  // s1..s3 reset high so a button held through reset never edges
  assign fwd_pulse = s2 & ~s3;
  assign trig = fwd_pulse | (auto_mode & (acnt == ALAST));
  assign tmo = (state == S_WAIT) & (tcnt == TLAST);

  always_comb begin
    state_nx = state;
    alu.alu_start = 1'b0;
    result_valid = 1'b0;
    busy = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (trig) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = S_ISSUE;
      S_ISSUE: begin
        alu.alu_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (alu.alu_done || tmo) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_valid = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      s1          <= 1'b1;
      s2          <= 1'b1;
      s3          <= 1'b1;
      acnt        <= '0;
      tcnt        <= '0;
      alu.A       <= '0;
      alu.B       <= '0;
      alu.op      <= '0;
      result      <= '0;
      vec_index   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      s1 <= forward;
      s2 <= s1;
      s3 <= s2;
      if (state == S_IDLE && auto_mode && !trig)
        acnt <= acnt + AW'(1);
      else
        acnt <= '0;
      if (state == S_WAIT)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (state == S_LOAD) begin
        {alu.A, alu.B, alu.op} <= tbl(vec_index);
        timeout_err <= 1'b0;
      end
      // done has priority over a simultaneous timeout
      if (state == S_WAIT) begin
        if (alu.alu_done) begin
          result <= alu.alu_result;
        end else if (tmo) begin
          result <= 32'hFFFF_FFFF;
          timeout_err <= 1'b1;
        end
      end
      if (state == S_CAPTURE)
        vec_index <= vec_index + 3'd1;
    end
  end

endmodule
